// File: rtl/pq_request_scheduler.sv
// Round-robin multi-client front end for the register-tree priority queue.
// Define PQ_SCHED_STATS_EN to add the o_stat_issued/o_stat_errors/o_stat_stall counters.
module pq_request_scheduler #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_WIDTH    = 16,
    parameter int QUEUE_SIZE    = 15,
    parameter int SETTLE_CYCLES = 2 * $clog2(QUEUE_SIZE)
) (
    input  logic                          i_CLK,
    input  logic                          i_RST,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    input  logic [2*NUM_REQ-1:0]          i_req_op,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
    output logic [NUM_REQ-1:0]            o_req_ready,
    output logic [NUM_REQ-1:0]            o_rsp_valid,
    output logic [DATA_WIDTH-1:0]         o_rsp_data,
    output logic                          o_rsp_err,
    output logic                          o_pq_wrt,
    output logic                          o_pq_read,
    output logic [DATA_WIDTH-1:0]         o_pq_data,
    input  logic                          i_pq_full,
    input  logic                          i_pq_empty,
    input  logic [DATA_WIDTH-1:0]         i_pq_data
`ifdef PQ_SCHED_STATS_EN
    ,
    output logic [31:0]                   o_stat_issued,
    output logic [31:0]                   o_stat_errors,
    output logic [31:0]                   o_stat_stall
`endif
);

    localparam int SETTLE_LEN = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
    localparam int CNT_W      = $clog2(SETTLE_LEN + 1);
    localparam int PTR_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP,
        SETTLE
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [PTR_W-1:0]      rr_ptr;
    logic [CNT_W-1:0]      settle_cnt;
    logic [1:0]            op_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] popped_q;
    logic [PTR_W-1:0]      grant_q;
    logic                  err_q;

    logic                  found;
    logic                  accept;
    logic [PTR_W-1:0]      grant;
    logic [PTR_W-1:0]      idx;
    logic [1:0]            grant_op;
    logic [DATA_WIDTH-1:0] grant_data;
    logic                  grant_err;

    // First valid client at or after the round-robin pointer, wrapping.
    always_comb begin
        found = 1'b0;
        grant = '0;
        idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = PTR_W'((32'(rr_ptr) + i) % NUM_REQ);
            if (!found && i_req_valid[idx]) begin
                found = 1'b1;
                grant = idx;
            end
        end
        grant_op   = i_req_op[2*grant +: 2];
        grant_data = i_req_data[DATA_WIDTH*grant +: DATA_WIDTH];
        case (grant_op)
            2'b01:   grant_err = i_pq_full || (grant_data == '0);
            2'b10:   grant_err = i_pq_empty;
            2'b11:   grant_err = (grant_data == '0);
            default: grant_err = 1'b1;
        endcase
        accept = (state == IDLE) && (settle_cnt == '0) && found && !i_RST;
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = ISSUE;
            ISSUE:   next_state = RESP;
            RESP:    next_state = err_q ? IDLE : SETTLE;
            SETTLE:  if (settle_cnt <= CNT_W'(1)) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        o_req_ready = '0;
        if (accept) o_req_ready[grant] = 1'b1;
        o_pq_wrt    = (state == ISSUE) && !err_q && op_q[0];
        o_pq_read   = (state == ISSUE) && !err_q && op_q[1];
        o_pq_data   = ((state == ISSUE) && !err_q) ? data_q : '0;
        o_rsp_valid = '0;
        if (state == RESP) o_rsp_valid[grant_q] = 1'b1;
        o_rsp_data  = (state == RESP) ? popped_q : '0;
        o_rsp_err   = (state == RESP) && err_q;
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            rr_ptr     <= '0;
            settle_cnt <= '0;
            op_q       <= '0;
            data_q     <= '0;
            popped_q   <= '0;
            grant_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            if (accept) begin
                op_q    <= grant_op;
                data_q  <= grant_data;
                grant_q <= grant;
                err_q   <= grant_err;
                rr_ptr  <= (grant == PTR_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
            end
            // Root is sampled before the queue pops, so it is the value removed.
            if (state == ISSUE)
                popped_q <= (!err_q && op_q[1]) ? i_pq_data : '0;
            if (state == RESP && !err_q)
                settle_cnt <= CNT_W'(SETTLE_LEN);
            else if (settle_cnt != '0)
                settle_cnt <= settle_cnt - 1'b1;
        end
    end

`ifdef PQ_SCHED_STATS_EN
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            o_stat_issued <= '0;
            o_stat_errors <= '0;
            o_stat_stall  <= '0;
        end else begin
            if (o_pq_wrt || o_pq_read)                o_stat_issued <= o_stat_issued + 32'd1;
            if (o_rsp_err)                            o_stat_errors <= o_stat_errors + 32'd1;
            if ((|i_req_valid) && (o_req_ready == '0)) o_stat_stall  <= o_stat_stall + 32'd1;
        end
    end
`endif

endmodule

// File: doc/pq_request_scheduler.md
# pq_request_scheduler

Multi-client front end for the register-tree priority queue. Arbitrates enqueue/dequeue/replace requests from `NUM_REQ` clients round-robin. Issues at most one single-cycle strobe to the queue. Enforces a compare-and-swap settle window before the next operation, and returns a per-client response carrying the popped value or an error.

## Interface
- `NUM_REQ`, 4: number of requesting clients (2..8).
- `DATA_WIDTH`, 16: key width; value 0 is reserved as "empty slot".
- `QUEUE_SIZE`, 15: capacity of the attached queue.
- `SETTLE_CYCLES`, 2*$clog2(QUEUE_SIZE): idle cycles after an issued op before the next op (minimum 1).
- `i_CLK` input 1: clock. One clock domain.
- `i_RST` input 1: reset, asynchronous, active-high.
- `i_req_valid` input NUM_REQ: per-client request valid.
- `i_req_op` input 2*NUM_REQ: per-client op (01 enqueue, 10 dequeue, 11 replace, 00 reserved).
- `i_req_data` input NUM_REQ*DATA_WIDTH: per-client key for enqueue/replace.
- `o_req_ready` output NUM_REQ: one-hot accept.
- `o_rsp_valid` output NUM_REQ: one-hot single-cycle response pulse.
- `o_rsp_data` output DATA_WIDTH: popped key for dequeue/replace; 0 otherwise.
- `o_rsp_err` output 1: request rejected, valid with `o_rsp_valid`.
- `o_pq_wrt`, `o_pq_read` output 1 each: queue strobes.
- `o_pq_data` output DATA_WIDTH: queue write data.
- `i_pq_full`, `i_pq_empty` input 1 each: queue status.
- `i_pq_data` input DATA_WIDTH: queue root, which holds the maximum.

## Operation
- FSM states are IDLE, ISSUE, RESP and SETTLE. Reset enters IDLE.
- **IDLE (T)**
  - Requires settle counter = 0 and at least one `i_req_valid`.
  - Picks grantee g as the first valid index at or after the RR pointer, wrapping.
  - Asserts `o_req_ready[g]` combinationally in T.
  - Latches op, data, g, and the error decision. Goes to ISSUE.
  - RR pointer becomes (g+1) mod NUM_REQ.
- **Error decision**, evaluated in T with status sampled in T. A request is rejected when any of these holds:
  - op 00;
  - enqueue with `i_pq_full`=1;
  - enqueue or replace with data 0;
  - dequeue with `i_pq_empty`=1.
  - Replace on an empty queue is legal; the queue grows by one.
- **ISSUE (T+1)**
  - Non-error op: drives exactly one cycle of strobes.
    - Enqueue: wrt=1, read=0.
    - Dequeue: wrt=0, read=1.
    - Replace: wrt=1, read=1.
    - `o_pq_data` = latched data.
  - Captures `i_pq_data` as the popped value for dequeue/replace.
  - Error op: strobes stay 0.
- **RESP (T+2)**
  - `o_rsp_valid[g]`=1 for one cycle.
  - `o_rsp_data` = popped value for dequeue/replace, else 0; it is also 0 on error.
  - `o_rsp_err` as decided in T.
  - Next state: SETTLE after a non-error op, IDLE after an error.
- **SETTLE**
  - Counter loads SETTLE_CYCLES on entry and decrements each cycle.
  - Returns to IDLE when it reaches 0; requests are not accepted meanwhile.
- `o_req_ready` is 0 in all states other than IDLE.
- Clients hold valid/op/data stable until ready. Dropping valid early is illegal and is not checked.

## Timing
- Reset values: all outputs 0, RR pointer 0, settle counter 0, state IDLE.
- Latency is fixed: accept at T, queue strobe at T+1, response at T+2.
- Throughput:
  - non-error ops, one per 3+SETTLE_CYCLES cycles;
  - error ops, one per 3 cycles.
- Simultaneous requests: exactly one grant per acceptance; non-grantees wait with ready=0.
- Queue strobes are never asserted for two consecutive cycles and never during RESP/SETTLE.
- Reset mid-operation:
  - an in-flight strobe or response is dropped;
  - the block returns to IDLE within the reset cycle;
  - no response is generated for the dropped request.

## Configuration
- `PQ_SCHED_STATS_EN` defined adds three outputs, each 32-bit, cleared by reset, wrapping at 2^32:
  - `o_stat_issued`, incremented in each ISSUE cycle with a strobe;
  - `o_stat_errors`, incremented in each RESP with err=1;
  - `o_stat_stall`, incremented in each cycle with any `i_req_valid`=1 and `o_req_ready`=0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

## Test plan
- **Reset and single enqueue.**
  - Stimulus: reset, then client 0 enqueues 5.
  - Required: ready at T; `o_pq_wrt`=1 and `o_pq_data`=5 only at T+1; `o_rsp_valid`=0001 with data 0 and err 0 at T+2; next accept no earlier than T+3+SETTLE_CYCLES.
- **Ordering.**
  - Stimulus: enqueue 5, 9, 3, then dequeue ×3 from client 2.
  - Required: responses return 9, 5, 3 in that order, each err=0.
- **Round-robin.**
  - Stimulus: all four clients hold an enqueue request continuously.
  - Required: grants go 0,1,2,3,0.
  - Stimulus: only clients 1 and 3 requesting, pointer at 2.
  - Required: client 3 granted first.
- **Error paths**, each giving err=1, data 0, no queue strobe, IDLE at T+3:
  - dequeue on empty;
  - enqueue of 0;
  - op 00;
  - enqueue with `i_pq_full`=1.
- **Replace.**
  - Stimulus: queue holds {9,4}; replace with 2.
  - Required: response data 9; both strobes high at T+1 only.
  - Stimulus: replace 7 on an empty queue.
  - Required: response data 0, err 0.
- **Reset during ISSUE.**
  - Stimulus: assert `i_RST` in the ISSUE cycle.
  - Required: strobes drop immediately; no `o_rsp_valid`; RR pointer 0; a new request is accepted in the first cycle after release.
